// File: rtl/rx_frame_decoder_pkg.sv
// ControlRx_in: constants and types shared by the UART frame decoder.
// Frame layout: HDR, L, CMD, payload (L-1 bytes), TAIL, where L counts CMD plus payload.
// Contents:
//   DataIn_t     - received byte type
//   rx_state_t   - decoder FSM state encoding
//   cmd_len_ok() - legal CMD/L pairing check
package ControlRx_in;

    typedef logic [7:0] DataIn_t;

    localparam DataIn_t HDR_BYTE     = 8'hFE;
    localparam DataIn_t TAIL_BYTE    = 8'hEF;
    localparam DataIn_t CMD_SET_SIZE = 8'h01;
    localparam DataIn_t CMD_START    = 8'h03;
    localparam DataIn_t CMD_LOAD     = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_CMD,
        ST_PAYLOAD,
        ST_TAIL
    } rx_state_t;

    // Each command accepts exactly one shape of length field.
    function automatic logic cmd_len_ok(input DataIn_t cmd, input DataIn_t len);
        logic ok;
        case (cmd)
            CMD_SET_SIZE: ok = (len == 8'd2);
            CMD_START:    ok = (len == 8'd1);
            CMD_LOAD:     ok = (len >= 8'd2);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rx_frame_decoder_if.sv
// rx_frame_decoder_if: byte input and scheduler/RAM outputs of the frame decoder.
//   rx_data/rx_valid      - received UART byte and its one-cycle strobe
//   Size_Matriz           - committed matrix size
//   enable_Data           - one-cycle start pulse
//   ram_we/addr/wdata     - RAM write port
//   frame_err             - one-cycle pulse on a rejected frame
//   busy                  - decoder is inside a frame
// slave modport faces the decoder, master modport faces the byte source.
interface rx_frame_decoder_if;
    import ControlRx_in::*;

    DataIn_t    rx_data;
    logic       rx_valid;
    logic [7:0] Size_Matriz;
    logic       enable_Data;
    logic       ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  rx_data, rx_valid,
        output Size_Matriz, enable_Data, ram_we, ram_addr, ram_wdata, frame_err, busy
    );

    modport master (
        output rx_data, rx_valid,
        input  Size_Matriz, enable_Data, ram_we, ram_addr, ram_wdata, frame_err, busy
    );

endinterface

// File: rtl/rx_frame_decoder_timeout.sv
// rx_timeout_counter: counts idle cycles between bytes of a frame.
//   clk, reset  - clock, synchronous active-high reset
//   clear_i     - restart the gap count (byte seen, idle, or timeout taken)
//   count_i     - count this cycle (decoder inside a frame)
//   timeout_o   - gap has reached TIMEOUT_CYC cycles
module rx_timeout_counter #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_i,
    output logic timeout_o
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_i && (cnt_q != W'(TIMEOUT_CYC))) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign timeout_o = (cnt_q == W'(TIMEOUT_CYC));

endmodule

// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: parses FE,L,CMD,payload,EF frames from a UART byte stream,
// writes load-data payload to RAM and commits size/start commands.
//   clk, reset - clock, synchronous active-high reset
//   bus        - rx_frame_decoder_if.slave (byte input, scheduler and RAM outputs)
// All outputs are registered: effects of a byte appear the cycle after its rx_valid.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for header byte, other bytes ignored
// ST_LEN     | next byte is length L
// ST_CMD     | next byte is the command code
// ST_PAYLOAD | consuming L-1 payload bytes
// ST_TAIL    | next byte must be the tail, commit on match
module rx_frame_decoder
    import ControlRx_in::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_N       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rx_frame_decoder_if.slave     bus
);

    localparam int MAX_L = MAX_N * MAX_N + MAX_N + 1;

    rx_state_t  state_q, state_d;
    DataIn_t    len_q, len_d;
    DataIn_t    cmd_q, cmd_d;
    DataIn_t    pay_cnt_q, pay_cnt_d;
    DataIn_t    pend_q, pend_d;
    DataIn_t    size_q, size_d;
    DataIn_t    wdata_q, wdata_d;
    logic [6:0] addr_q, addr_d;
    logic       we_q, we_d;
    logic       en_q, en_d;
    logic       err_q, err_d;

    logic busy;
    logic timeout;
    logic len_bad;
    logic cmd_bad;
    logic last_payload;

    assign busy         = (state_q != ST_IDLE);
    assign len_bad      = (bus.rx_data == 8'h00) || (int'(bus.rx_data) > MAX_L);
    assign cmd_bad      = !cmd_len_ok(bus.rx_data, len_q);
    assign last_payload = (pay_cnt_q == len_q - 8'd2);

    // Clearing on timeout keeps the expired count from re-firing while the FSM drops to idle.
    rx_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (bus.rx_valid || !busy || timeout),
        .count_i   (busy),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout wins over a byte arriving in the same cycle; that byte is dropped.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE:    if (bus.rx_data == HDR_BYTE) state_d = ST_LEN;
                ST_LEN:     state_d = len_bad ? ST_IDLE : ST_CMD;
                ST_CMD: begin
                    if (cmd_bad)             state_d = ST_IDLE;
                    else if (len_q == 8'd1)  state_d = ST_TAIL;
                    else                     state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: if (last_payload) state_d = ST_TAIL;
                ST_TAIL:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        len_d     = len_q;
        cmd_d     = cmd_q;
        pay_cnt_d = pay_cnt_q;
        pend_d    = pend_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        en_d      = 1'b0;
        err_d     = 1'b0;
        if (timeout) begin
            err_d = 1'b1;
        end else if (bus.rx_valid) begin
            case (state_q)
                ST_LEN: begin
                    if (len_bad) err_d = 1'b1;
                    else         len_d = bus.rx_data;
                end
                ST_CMD: begin
                    cmd_d     = bus.rx_data;
                    pay_cnt_d = '0;
                    err_d     = cmd_bad;
                end
                ST_PAYLOAD: begin
                    pay_cnt_d = pay_cnt_q + 8'd1;
                    if (cmd_q == CMD_LOAD) begin
                        we_d    = 1'b1;
                        addr_d  = pay_cnt_q[6:0];
                        wdata_d = bus.rx_data;
                    end else begin
                        pend_d  = bus.rx_data;
                    end
                end
                ST_TAIL: begin
                    if (bus.rx_data != TAIL_BYTE) begin
                        err_d = 1'b1;
                    end else if (cmd_q == CMD_SET_SIZE) begin
                        if (pend_q == 8'h00 || int'(pend_q) > MAX_N) err_d  = 1'b1;
                        else                                          size_d = pend_q;
                    end else if (cmd_q == CMD_START) begin
                        if (size_q == 8'h00) err_d = 1'b1;
                        else                 en_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= '0;
            cmd_q     <= '0;
            pay_cnt_q <= '0;
            pend_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            pay_cnt_q <= pay_cnt_d;
            pend_q    <= pend_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            en_q      <= en_d;
            err_q     <= err_d;
        end
    end

    assign bus.Size_Matriz = size_q;
    assign bus.enable_Data = en_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_wdata   = wdata_q;
    assign bus.frame_err   = err_q;
    assign bus.busy        = busy;

endmodule
